// File: rtl/adsr_env.sv
// adsr_env: amplitude envelope stage for the vsynth voice path.
//
// Runs an attack/decay/sustain/release envelope driven by the MIDI gate
// (velocity != 0) and scales the oscillator sample by the current level.
//
// Ports:
//   CLK         system clock (single domain)
//   RST         asynchronous active-high reset
//   CE          clock enable; when low every register holds
//   NOTE_NUM    current note number from the MIDI parser
//   NOTE_VEL    current velocity; 0 means note off
//   SAMPLE_IN   oscillator sample, offset binary (128 = zero)
//   SAMPLE_OUT  enveloped sample, offset binary, 2 CE clocks after SAMPLE_IN
//   ENV_LEVEL   current envelope level 0..255
//   ENV_STATE   IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   BUSY        high whenever ENV_STATE != IDLE
//
// There is no handshake: SAMPLE_IN is taken every CE clock and SAMPLE_OUT
// is a continuously valid registered stream.
module adsr_env #(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned ATTACK_INC  = 8,
  parameter int unsigned DECAY_DEC   = 2,
  parameter int unsigned SUSTAIN_LVL = 192,
  parameter int unsigned RELEASE_DEC = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic [6:0] NOTE_NUM,
  input  logic [6:0] NOTE_VEL,
  input  logic [7:0] SAMPLE_IN,
  output logic [7:0] SAMPLE_OUT,
  output logic [7:0] ENV_LEVEL,
  output logic [2:0] ENV_STATE,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [8:0] ATK9 = 9'(ATTACK_INC);
  localparam logic [8:0] DEC9 = 9'(DECAY_DEC);
  localparam logic [8:0] REL9 = 9'(RELEASE_DEC);
  localparam logic [7:0] SUS8 = 8'(SUSTAIN_LVL);

  // Registers
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               gate_q;
  logic [6:0]         note_q;
  state_t             state_q, state_d;
  logic [7:0]         level_q, level_d;
  logic signed [17:0] prod_q, prod_d;
  logic [7:0]         out_q, out_d;

  // Event decode
  logic gate, tick, gate_rise, gate_fall, retrig;
  logic [8:0] add9, dec9, rel9;

  assign gate      = (NOTE_VEL != 7'd0);
  assign tick      = (cnt_q == TICK_LAST);
  assign gate_rise = gate & ~gate_q;
  assign gate_fall = ~gate & gate_q;
  assign retrig    = gate & gate_q & (NOTE_NUM != note_q) & (state_q != ST_IDLE);

  // Free-running step counter; gate activity never restarts it.
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // 9-bit arithmetic: bit 8 is carry (attack) or borrow (decay/release),
  // which makes saturation exact.
  assign add9 = {1'b0, level_q} + ATK9;
  assign dec9 = {1'b0, level_q} - DEC9;
  assign rel9 = {1'b0, level_q} - REL9;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    // Gate events win over level stepping on the same edge; a fall beats a
    // simultaneous note change.
    if (gate_fall && (state_q != ST_IDLE)) begin
      state_d = ST_RELEASE;
    end else if (gate_rise || retrig) begin
      // Attack restarts from the current level so there is no click.
      state_d = ST_ATTACK;
    end else if (tick) begin
      case (state_q)
        ST_ATTACK: begin
          if (add9 >= 9'd255) begin
            level_d = 8'd255;
            state_d = ST_DECAY;
          end else begin
            level_d = add9[7:0];
          end
        end
        ST_DECAY: begin
          if (dec9[8] || (dec9[7:0] <= SUS8)) begin
            level_d = SUS8;
            state_d = ST_SUSTAIN;
          end else begin
            level_d = dec9[7:0];
          end
        end
        ST_RELEASE: begin
          if (rel9[8] || (rel9[7:0] == 8'd0)) begin
            level_d = 8'd0;
            state_d = ST_IDLE;
          end else begin
            level_d = rel9[7:0];
          end
        end
        ST_SUSTAIN: level_d = level_q;
        default:    level_d = 8'd0;
      endcase
    end
  end

  // Scaling pipeline. Stage 1 uses the level registered at the same edge.
  logic signed [8:0] s9, lvl9;
  assign s9   = $signed({1'b0, SAMPLE_IN}) - 9'sd128;
  assign lvl9 = $signed({1'b0, level_q});
  // |product| <= 128*255, so 18 bits hold it without overflow.
  assign prod_d = 18'(s9) * 18'(lvl9);
  // prod_q[15:8] equals (prod_q >>> 8) truncated to 8 bits; the shifted value
  // lies in -128..126, so adding 128 modulo 256 gives the offset-binary result.
  assign out_d = prod_q[15:8] + 8'd128;

  logic prod_unused;
  assign prod_unused = ^{prod_q[17:16], prod_q[7:0]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      gate_q  <= 1'b0;
      note_q  <= 7'd0;
      state_q <= ST_IDLE;
      level_q <= 8'd0;
      prod_q  <= '0;
      out_q   <= 8'd128;
    end else if (CE) begin
      cnt_q   <= cnt_d;
      gate_q  <= gate;
      note_q  <= NOTE_NUM;
      state_q <= state_d;
      level_q <= level_d;
      prod_q  <= prod_d;
      out_q   <= out_d;
    end
  end

  assign SAMPLE_OUT = out_q;
  assign ENV_LEVEL  = level_q;
  assign ENV_STATE  = state_q;
  assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: doc/adsr_env.md
# adsr_env

Amplitude envelope stage sitting directly downstream of the `nco` oscillator in the vsynth voice path. It consumes the oscillator's 8-bit offset-binary sample, plus the MIDI note/velocity state from the `midi` parser. It runs an attack/decay/sustain/release envelope and outputs the sample scaled by the current envelope level. Its output drives the board DAC pins in place of the raw oscillator sample.

## Interface

Parameters:
- `TICK_DIV`, default 50000: CE-qualified clocks per envelope step (1 kHz step rate at 50 MHz).
- `ATTACK_INC`, default 8: level increment per tick in ATTACK.
- `DECAY_DEC`, default 2: level decrement per tick in DECAY.
- `SUSTAIN_LVL`, default 192: sustain level, 0..255.
- `RELEASE_DEC`, default 1: level decrement per tick in RELEASE.

Ports:
- `CLK`  in  1: system clock. One clock domain only.
- `RST`  in  1: asynchronous, active-high reset.
- `CE`  in  1: clock enable. When low, all state freezes (tick counter, FSM, level, pipeline).
- `NOTE_NUM`  in  7: current note from `midi`.
- `NOTE_VEL`  in  7: current velocity from `midi`. A value of 0 means note off.
- `SAMPLE_IN`  in  8: oscillator sample, offset binary (128 = zero).
- `SAMPLE_OUT`  out  8: enveloped sample, offset binary.
- `ENV_LEVEL`  out  8: current envelope level, 0..255.
- `ENV_STATE`  out  3: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `BUSY`  out  1: high whenever `ENV_STATE` != IDLE.

## Operation

- **Gate.** `gate = (NOTE_VEL != 0)`, registered as `gate_q`. `NOTE_NUM` is registered as `note_q`.
- **Tick counter.** Counts 0..TICK_DIV-1 on each CE clock and wraps. `tick` is asserted when count == TICK_DIV-1. The counter free-runs from reset and is never restarted by gate events.
- **Gate events** (evaluated every CE clock, independent of `tick`; they take priority over level stepping on the same edge):
  - Gate rise (`gate & ~gate_q`): go to ATTACK from the current level. There is no reset to 0, so there is no click.
  - Gate fall (`~gate & gate_q`): go to RELEASE from any state except IDLE.
  - Retrigger (`gate & gate_q & NOTE_NUM != note_q`) while not IDLE: go to ATTACK from the current level.
  - If a gate fall and a note change occur together, the gate fall (RELEASE) wins.
- **Level stepping** (only on `tick`, with no gate event on the same edge):
  - ATTACK: level = min(level + ATTACK_INC, 255). When the result reaches 255, go to DECAY.
  - DECAY: level = max(level − DECAY_DEC, SUSTAIN_LVL). When the result equals SUSTAIN_LVL, go to SUSTAIN. If SUSTAIN_LVL = 255, the first DECAY tick moves straight to SUSTAIN.
  - SUSTAIN: level is held.
  - RELEASE: level = max(level − RELEASE_DEC, 0). When the result reaches 0, go to IDLE.
  - IDLE: level stays 0.
- **Arithmetic.** Use a 9-bit intermediate for the add and subtract so saturation is exact and there is no wrap.
- **Scaling.**
  - `s = signed(SAMPLE_IN) − 128`, 9-bit signed.
  - `p = s × {1'b0, level}`, 18-bit signed.
  - `SAMPLE_OUT = (p >>> 8) + 128`, arithmetic shift with floor. The result is always within 0..254, so no clamp is needed.
  - Level 0 gives a constant 128.

## Timing

- **Reset values:**
  - `SAMPLE_OUT` = 128.
  - `ENV_LEVEL` = 0.
  - `ENV_STATE` = IDLE.
  - `BUSY` = 0.
  - Tick counter, `gate_q` and `note_q` = 0.
- **Gate change to state change:** `ENV_STATE` changes on the first CE rising edge after `NOTE_VEL` changes (1 clock).
- **Level update:** `ENV_LEVEL` changes on the edge where `tick` is high.
- **Sample latency:** 2 CE clocks from `SAMPLE_IN` to `SAMPLE_OUT`.
  - Stage 1 registers the product, using `ENV_LEVEL` as registered at that edge.
  - Stage 2 registers the shift plus offset.
- **Reset mid-note:** outputs return to their reset values immediately (asynchronous). After release, if `NOTE_VEL` is still nonzero, the next CE edge sees a gate rise and starts ATTACK from 0.
- **CE low:** no register changes. A gate edge that happens while CE is low is seen at the next CE clock.

## Test plan

Parameters for scenarios 1–5: TICK_DIV=4, ATTACK_INC=64, DECAY_DEC=16, SUSTAIN_LVL=192, RELEASE_DEC=32.

1. **Full envelope.** Drive NOTE_VEL=100 and hold.
   - ATTACK levels on successive ticks: 64, 128, 192, 255, then DECAY.
   - DECAY levels: 239, 223, 207, 192, then SUSTAIN, held.
   - Drive NOTE_VEL=0: RELEASE next clock, levels 160, 128, 96, 64, 32, 0, then IDLE with BUSY=0.
2. **Early release.** Drop the gate when level = 128 in ATTACK.
   - State is RELEASE 1 clock later, with the level still 128.
   - Next tick level is 96.
3. **Retrigger.**
   - In SUSTAIN (level 192), change NOTE_NUM 60→64 with NOTE_VEL unchanged: ATTACK next clock, next tick level 255.
   - In RELEASE at level 96, raise the gate: ATTACK, next tick level 160.
4. **Simultaneous events.** In SUSTAIN, change NOTE_NUM and set NOTE_VEL=0 on the same clock: state goes to RELEASE, not ATTACK.
5. **Scaling.** Check each case 2 clocks after input is applied.
   - Level 255: SAMPLE_IN=255 → 254; SAMPLE_IN=0 → 0; SAMPLE_IN=128 → 128.
   - Level 128: SAMPLE_IN=0 → 64.
   - Level 0: any input → 128.
6. **CE and reset.**
   - Hold CE=0 for 20 clocks in ATTACK: level and state are unchanged.
   - Assert RST mid-DECAY, not aligned to any clock edge: outputs go to 128/0/IDLE immediately.
